// File: rtl/b06_eql_gen.sv
// Reference-compare match generator: holds a reference word, flags masked matches
// to a downstream controller, and runs a wait counter with terminal-count detect.
module b06_eql_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int TERM  = 9
) (
    input  logic             clock,
    input  logic             nRESET_G,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             DATA_VLD,
    input  logic             LOAD_REF,
    input  logic             CC_MUX_REG_2_,
    input  logic             CC_MUX_REG_1_,
    input  logic             ENABLE_COUNT_REG,
    input  logic             ACKOUT_REG,
    output logic             EQL,
    output logic             CONT_EQL,
    output logic [CNT_W-1:0] COUNT,
    output logic             DROP
);

    localparam int               HALF   = WIDTH / 2;
    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ref_q;
    logic             ack_prev;

    logic             mode_match;
    logic             ack_rise;
    logic [CNT_W-1:0] count_nxt;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        mode_match = 1'b0;
        case ({CC_MUX_REG_2_, CC_MUX_REG_1_})
            2'b00:   mode_match = (DATA_IN == ref_q);
            2'b01:   mode_match = (DATA_IN[HALF-1:0] == ref_q[HALF-1:0]);
            2'b10:   mode_match = (DATA_IN[WIDTH-1 -: HALF] == ref_q[WIDTH-1 -: HALF]);
            default: mode_match = 1'b0;
        endcase

        // An acknowledge edge restarts the wait, taking priority over the enable.
        ack_rise  = ACKOUT_REG & ~ack_prev;
        count_nxt = COUNT;
        if (ack_rise)
            count_nxt = '0;
        else if (ENABLE_COUNT_REG)
            count_nxt = (COUNT == TERM_C) ? '0 : COUNT + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!nRESET_G) begin
            state    <= IDLE;
            ref_q    <= '0;
            ack_prev <= 1'b0;
            EQL      <= 1'b0;
            CONT_EQL <= 1'b0;
            COUNT    <= '0;
            DROP     <= 1'b0;
        end else begin
            ack_prev <= ACKOUT_REG;
            COUNT    <= count_nxt;
            CONT_EQL <= (count_nxt == TERM_C);
            DROP     <= 1'b0;

            case (state)
                IDLE: begin
                    EQL <= 1'b0;
                    if (DATA_VLD && LOAD_REF) begin
                        ref_q <= DATA_IN;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (DATA_VLD) begin
                        if (LOAD_REF) begin
                            ref_q <= DATA_IN;
                        end else if (mode_match) begin
                            state <= HIT;
                            EQL   <= 1'b1;
                        end
                    end
                end
                HIT: begin
                    // A pending match blocks new samples; LOAD_REF is ignored too.
                    DROP <= DATA_VLD;
                    if (ACKOUT_REG) begin
                        state <= CMP;
                        EQL   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    EQL   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b06_eql_gen.sv
// Directed bench for b06_eql_gen: table of compare/FSM vectors plus
// hand-written counter, acknowledge-clear and mid-HIT reset sequences.
module tb_b06_eql_gen;

    logic       clock = 1'b0;
    logic       nRESET_G = 1'b0;
    logic [7:0] DATA_IN = '0;
    logic       DATA_VLD = 1'b0;
    logic       LOAD_REF = 1'b0;
    logic       CC_MUX_REG_2_ = 1'b0;
    logic       CC_MUX_REG_1_ = 1'b0;
    logic       ENABLE_COUNT_REG = 1'b0;
    logic       ACKOUT_REG = 1'b0;
    logic       EQL;
    logic       CONT_EQL;
    logic [3:0] COUNT;
    logic       DROP;

    int n_checks = 0;
    int n_fail   = 0;

    b06_eql_gen #(.WIDTH(8), .CNT_W(4), .TERM(9)) dut (
        .clock            (clock),
        .nRESET_G         (nRESET_G),
        .DATA_IN          (DATA_IN),
        .DATA_VLD         (DATA_VLD),
        .LOAD_REF         (LOAD_REF),
        .CC_MUX_REG_2_    (CC_MUX_REG_2_),
        .CC_MUX_REG_1_    (CC_MUX_REG_1_),
        .ENABLE_COUNT_REG (ENABLE_COUNT_REG),
        .ACKOUT_REG       (ACKOUT_REG),
        .EQL              (EQL),
        .CONT_EQL         (CONT_EQL),
        .COUNT            (COUNT),
        .DROP             (DROP)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       vld;
        logic       load;
        logic       ack;
        logic [1:0] mode;
        logic [7:0] din;
        logic       exp_eql;
        logic       exp_drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst_n, input logic vld, input logic load,
                       input logic ack, input logic [1:0] mode, input logic [7:0] din,
                       input logic exp_eql, input logic exp_drop);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.vld = vld; v.load = load; v.ack = ack;
        v.mode = mode; v.din = din; v.exp_eql = exp_eql; v.exp_drop = exp_drop;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic vld, input logic load, input logic ack,
                         input logic [1:0] mode, input logic [7:0] din, input logic en);
        nRESET_G = rst_n; DATA_VLD = vld; LOAD_REF = load; ACKOUT_REG = ack;
        {CC_MUX_REG_2_, CC_MUX_REG_1_} = mode; DATA_IN = din; ENABLE_COUNT_REG = en;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        tick();
        nRESET_G = 1'b1;
    endtask

    initial begin
        //   name              rst vld ld ack mode   din    eql drop
        add("reset",           0,  0,  0, 0,  2'b00, 8'h00, 0,  0);
        add("idle_ignore_1",   1,  1,  0, 0,  2'b00, 8'h00, 0,  0);
        add("idle_ignore_2",   1,  1,  0, 0,  2'b00, 8'h00, 0,  0);
        add("load_a5",         1,  1,  1, 0,  2'b00, 8'hA5, 0,  0);
        add("cmp_idle",        1,  0,  0, 0,  2'b00, 8'h00, 0,  0);
        add("full_match",      1,  1,  0, 0,  2'b00, 8'hA5, 1,  0);
        add("hit_hold_1",      1,  0,  0, 0,  2'b00, 8'h00, 1,  0);
        add("hit_hold_2",      1,  0,  0, 0,  2'b00, 8'h00, 1,  0);
        add("ack_clears",      1,  0,  0, 1,  2'b00, 8'h00, 0,  0);
        add("ack_low_cmp",     1,  0,  0, 0,  2'b00, 8'h00, 0,  0);
        add("ack_outside_hit", 1,  0,  0, 1,  2'b00, 8'h00, 0,  0);
        add("mode01_match",    1,  1,  0, 0,  2'b01, 8'h35, 1,  0);
        add("mode01_ack",      1,  0,  0, 1,  2'b00, 8'h00, 0,  0);
        add("mode10_miss",     1,  1,  0, 0,  2'b10, 8'h35, 0,  0);
        add("mode11_disabled", 1,  1,  0, 0,  2'b11, 8'hA5, 0,  0);
        add("mode00_miss",     1,  1,  0, 0,  2'b00, 8'hA4, 0,  0);
        add("rematch",         1,  1,  0, 0,  2'b00, 8'hA5, 1,  0);
        add("hit_drop_1",      1,  1,  0, 0,  2'b00, 8'hA5, 1,  1);
        add("hit_drop_load",   1,  1,  1, 0,  2'b00, 8'h3C, 1,  1);
        add("ack_with_vld",    1,  1,  0, 1,  2'b00, 8'hA5, 0,  1);
        add("after_ack_quiet", 1,  0,  0, 0,  2'b00, 8'h00, 0,  0);
        add("ref_not_reloaded",1,  1,  0, 0,  2'b00, 8'hA5, 1,  0);
        add("ack_again",       1,  0,  0, 1,  2'b00, 8'h00, 0,  0);
        add("cmp_reload_3c",   1,  1,  1, 0,  2'b00, 8'h3C, 0,  0);
        add("old_ref_miss",    1,  1,  0, 0,  2'b00, 8'hA5, 0,  0);
        add("new_ref_match",   1,  1,  0, 0,  2'b00, 8'h3C, 1,  0);
        add("final_ack",       1,  0,  0, 1,  2'b00, 8'h00, 0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].vld, vecs[i].load, vecs[i].ack,
                  vecs[i].mode, vecs[i].din, 1'b0);
            tick();
            check({vecs[i].name, ".eql"},   32'(EQL),      32'(vecs[i].exp_eql));
            check({vecs[i].name, ".drop"},  32'(DROP),     32'(vecs[i].exp_drop));
            check({vecs[i].name, ".count"}, 32'(COUNT),    32'd0);
            check({vecs[i].name, ".cont"},  32'(CONT_EQL), 32'd0);
        end

        // Free-running count from reset: 1..9, wrap to 0, 1, 2.
        do_reset();
        check("cnt_reset", 32'(COUNT), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
            tick();
            check($sformatf("cnt_step%0d.count", k), 32'(COUNT), 32'(k % 10));
            check($sformatf("cnt_step%0d.cont", k), 32'(CONT_EQL), 32'(k == 9));
        end

        // Ack rising edge clears the counter over a held enable; a held ack does not.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
            tick();
        end
        check("ack_clr_pre", 32'(COUNT), 32'd5);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 1'b1);
        tick();
        check("ack_clr_rise", 32'(COUNT), 32'd0);
        tick();
        check("ack_clr_held", 32'(COUNT), 32'd1);

        // Reset in HIT with COUNT=7.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 8'hA5, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'hA5, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        check("hit7.eql", 32'(EQL), 32'd1);
        check("hit7.count", 32'(COUNT), 32'd7);
        // A reset pulse between edges must not act.
        #2 nRESET_G = 1'b0;
        #1 nRESET_G = 1'b1;
        #1;
        check("no_edge_reset.count", 32'(COUNT), 32'd7);
        check("no_edge_reset.eql", 32'(EQL), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 8'hA5, 1'b1);
        tick();
        check("mid_hit_rst.eql",   32'(EQL),      32'd0);
        check("mid_hit_rst.count", 32'(COUNT),    32'd0);
        check("mid_hit_rst.cont",  32'(CONT_EQL), 32'd0);
        check("mid_hit_rst.drop",  32'(DROP),     32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        tick();
        check("post_rst_idle_1.eql",  32'(EQL),  32'd0);
        check("post_rst_idle_1.drop", 32'(DROP), 32'd0);
        tick();
        check("post_rst_idle_2.eql",  32'(EQL),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
